cpu_sequencer: RTL and testbench

- Multi-cycle control sequencer for the MIPS CPU core.
- Generates the one-hot phase strobes (fetch, exec1, exec2) that drive the memory-access unit and register/PC write-back.
- Stalls phases on bus waitrequest, captures instruction and load data words from the memory bus, and detects the halt condition.
- Enforces a bus watchdog that halts the core on a hung memory.

---
 rtl/cpu_sequencer_if.sv | 39 +++
 rtl/cpu_sequencer.sv | 145 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
//------------------------------------------------------------------------------
// cpu_sequencer_if : memory bus, decode hints and phase outputs of the sequencer
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cpu_sequencer_if #(
  parameter int STALL_W = 16
);
  logic               waitrequest;
  logic [31:0]        readdata;
  logic               mem_op;
  logic               mem_is_load;
  logic               halt_req;
  logic               fetch;
  logic               exec1;
  logic               exec2;
  logic [31:0]        instr_reg;
  logic [31:0]        data_reg;
  logic               pc_en;
  logic               reg_we_en;
  logic               active;
  logic               bus_error;
  logic [STALL_W-1:0] stall_count;

  modport master (
    input  waitrequest, readdata, mem_op, mem_is_load, halt_req,
    output fetch, exec1, exec2, instr_reg, data_reg, pc_en, reg_we_en,
           active, bus_error, stall_count
  );

  modport slave (
    output waitrequest, readdata, mem_op, mem_is_load, halt_req,
    input  fetch, exec1, exec2, instr_reg, data_reg, pc_en, reg_we_en,
           active, bus_error, stall_count
  );
endinterface

`default_nettype wire

// File: rtl/cpu_sequencer.sv
//------------------------------------------------------------------------------
// cpu_sequencer : multi-cycle fetch/exec1/exec2 sequencer with bus watchdog
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cpu_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STALL_W        = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  cpu_sequencer_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**STALL_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range for STALL_W");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC1  = 3'd2,
    EXEC2  = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [STALL_W-1:0] STALL_MAX    = '1;
  localparam logic [STALL_W-1:0] STALL_ONE    = STALL_W'(1);
  localparam logic [STALL_W-1:0] TIMEOUT_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [5:0]         phase;   // {active, fetch, exec1, exec2, pc_en, reg_we_en}
  logic [STALL_W-1:0] wait_cnt;
  logic [STALL_W-1:0] stall_count;
  logic [31:0]        instr_reg;
  logic [31:0]        data_reg;
  logic               bus_error;
  logic               stalled;
  logic               timeout;

  function automatic logic [5:0] phase_bits(input state_t s);
    case (s)
      FETCH:   phase_bits = 6'b110000;
      EXEC1:   phase_bits = 6'b101000;
      EXEC2:   phase_bits = 6'b100111;
      default: phase_bits = 6'b000000;
    endcase
  endfunction

  assign stalled = bus.waitrequest &&
                   ((state == FETCH) || ((state == EXEC1) && bus.mem_op));
  // A phase completing on the cycle the counter would expire is not an error.
  assign timeout = stalled && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      phase       <= 6'b000000;
      wait_cnt    <= '0;
      stall_count <= '0;
      instr_reg   <= '0;
      data_reg    <= '0;
      bus_error   <= 1'b0;
    end else begin
      if (stalled && (stall_count != STALL_MAX))
        stall_count <= stall_count + STALL_ONE;

      case (state)
        IDLE: begin
          state    <= FETCH;
          phase    <= phase_bits(FETCH);
          wait_cnt <= '0;
        end

        FETCH: begin
          if (timeout) begin
            bus_error <= 1'b1;
            state     <= HALTED;
            phase     <= phase_bits(HALTED);
          end else if (stalled) begin
            wait_cnt <= wait_cnt + STALL_ONE;
          end else begin
            instr_reg <= bus.readdata;
            wait_cnt  <= '0;
            state     <= EXEC1;
            phase     <= phase_bits(EXEC1);
          end
        end

        EXEC1: begin
          if (timeout) begin
            bus_error <= 1'b1;
            state     <= HALTED;
            phase     <= phase_bits(HALTED);
          end else if (stalled) begin
            wait_cnt <= wait_cnt + STALL_ONE;
          end else begin
            if (bus.mem_op && bus.mem_is_load)
              data_reg <= bus.readdata;
            wait_cnt <= '0;
            state    <= EXEC2;
            phase    <= phase_bits(EXEC2);
          end
        end

        EXEC2: begin
          wait_cnt <= '0;
          if (bus.halt_req) begin
            state <= HALTED;
            phase <= phase_bits(HALTED);
          end else begin
            state <= FETCH;
            phase <= phase_bits(FETCH);
          end
        end

        HALTED: begin
          state <= HALTED;
          phase <= phase_bits(HALTED);
        end

        default: begin
          state    <= IDLE;
          phase    <= phase_bits(IDLE);
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.active      = phase[5];
  assign bus.fetch       = phase[4];
  assign bus.exec1       = phase[3];
  assign bus.exec2       = phase[2];
  assign bus.pc_en       = phase[1];
  assign bus.reg_we_en   = phase[0];
  assign bus.instr_reg   = instr_reg;
  assign bus.data_reg    = data_reg;
  assign bus.bus_error   = bus_error;
  assign bus.stall_count = stall_count;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
//------------------------------------------------------------------------------
// tb_cpu_sequencer : directed self-checking bench for cpu_sequencer
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_sequencer;

  // Phase vectors: {active, fetch, exec1, exec2, pc_en, reg_we_en}
  localparam logic [5:0] P_IDLE = 6'b000000;
  localparam logic [5:0] P_F    = 6'b110000;
  localparam logic [5:0] P_E1   = 6'b101000;
  localparam logic [5:0] P_E2   = 6'b100111;
  localparam logic [5:0] P_H    = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        mem_op;
  logic        mem_is_load;
  logic        halt_req;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.STALL_W(16)) if_m ();
  cpu_sequencer_if #(.STALL_W(16)) if_t ();
  cpu_sequencer_if #(.STALL_W(3))  if_s ();

  assign if_m.waitrequest = waitrequest;
  assign if_m.readdata    = readdata;
  assign if_m.mem_op      = mem_op;
  assign if_m.mem_is_load = mem_is_load;
  assign if_m.halt_req    = halt_req;
  assign if_t.waitrequest = waitrequest;
  assign if_t.readdata    = readdata;
  assign if_t.mem_op      = mem_op;
  assign if_t.mem_is_load = mem_is_load;
  assign if_t.halt_req    = halt_req;
  assign if_s.waitrequest = waitrequest;
  assign if_s.readdata    = readdata;
  assign if_s.mem_op      = mem_op;
  assign if_s.mem_is_load = mem_is_load;
  assign if_s.halt_req    = halt_req;

  cpu_sequencer #(.TIMEOUT_CYCLES(1024), .STALL_W(16)) dut_m (.clk(clk), .reset(reset), .bus(if_m));
  cpu_sequencer #(.TIMEOUT_CYCLES(4),    .STALL_W(16)) dut_t (.clk(clk), .reset(reset), .bus(if_t));
  cpu_sequencer #(.TIMEOUT_CYCLES(7),    .STALL_W(3))  dut_s (.clk(clk), .reset(reset), .bus(if_s));

  logic [5:0] ph_m, ph_t, ph_s;
  assign ph_m = {if_m.active, if_m.fetch, if_m.exec1, if_m.exec2, if_m.pc_en, if_m.reg_we_en};
  assign ph_t = {if_t.active, if_t.fetch, if_t.exec1, if_t.exec2, if_t.pc_en, if_t.reg_we_en};
  assign ph_s = {if_s.active, if_s.fetch, if_s.exec1, if_s.exec2, if_s.pc_en, if_s.reg_we_en};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive bus inputs for the current cycle, then move just past the next edge.
  task automatic step(input logic wr, input logic [31:0] rd);
    waitrequest = wr;
    readdata    = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 0, 1);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] held_instr;
    reset = 1'b0; waitrequest = 1'b0; readdata = '0;
    mem_op = 1'b0; mem_is_load = 1'b0; halt_req = 1'b0;

    // Reset state; first cycle after release is the single IDLE cycle
    do_reset();
    check_eq("rst_phase", 32'(ph_m), 32'(P_IDLE));
    check_eq("rst_instr", if_m.instr_reg, 32'h0);
    check_eq("rst_data", if_m.data_reg, 32'h0);
    check_eq("rst_stall", 32'(if_m.stall_count), 32'h0);
    check_eq("rst_buserr", 32'(if_m.bus_error), 32'h0);

    // Back-to-back ALU instructions, no waits
    step(1'b0, 32'h24080005); check_eq("t1_c2_fetch", 32'(ph_m), 32'(P_F));
    step(1'b0, 32'h24080005); check_eq("t1_c3_exec1", 32'(ph_m), 32'(P_E1));
    check_eq("t1_instr", if_m.instr_reg, 32'h24080005);
    step(1'b0, 32'h24080005); check_eq("t1_c4_exec2", 32'(ph_m), 32'(P_E2));
    step(1'b0, 32'h24080005); check_eq("t1_c5_fetch", 32'(ph_m), 32'(P_F));

    // Load: 2 fetch stalls, 3 exec1 stalls -> 8-cycle instruction
    mem_op = 1'b1; mem_is_load = 1'b1;
    step(1'b1, 32'h11111111); check_eq("t2_fstall1", 32'(ph_m), 32'(P_F));
    step(1'b1, 32'h22222222); check_eq("t2_fstall2", 32'(ph_m), 32'(P_F));
    step(1'b0, 32'h8C080000); check_eq("t2_exec1", 32'(ph_m), 32'(P_E1));
    check_eq("t2_instr", if_m.instr_reg, 32'h8C080000);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h33333333); check_eq("t2_e1stall", 32'(ph_m), 32'(P_E1));
    end
    check_eq("t2_instr_hold", if_m.instr_reg, 32'h8C080000);
    step(1'b0, 32'hDEADBEEF); check_eq("t2_exec2", 32'(ph_m), 32'(P_E2));
    check_eq("t2_data", if_m.data_reg, 32'hDEADBEEF);
    check_eq("t2_stall", 32'(if_m.stall_count), 32'd5);
    step(1'b0, 32'h0); check_eq("t2_next_fetch", 32'(ph_m), 32'(P_F));

    // Store: data_reg untouched
    mem_is_load = 1'b0;
    step(1'b0, 32'hAC080000); check_eq("t3_exec1", 32'(ph_m), 32'(P_E1));
    step(1'b0, 32'h12345678); check_eq("t3_exec2", 32'(ph_m), 32'(P_E2));
    check_eq("t3_data_hold", if_m.data_reg, 32'hDEADBEEF);
    step(1'b0, 32'h0); check_eq("t3_next_fetch", 32'(ph_m), 32'(P_F));

    // No data access: waitrequest in exec1 is ignored and not counted
    mem_op = 1'b0;
    step(1'b0, 32'h01094020); check_eq("t4_exec1", 32'(ph_m), 32'(P_E1));
    step(1'b1, 32'h55555555); check_eq("t4_exec2", 32'(ph_m), 32'(P_E2));
    check_eq("t4_stall", 32'(if_m.stall_count), 32'd5);
    check_eq("t4_data_hold", if_m.data_reg, 32'hDEADBEEF);
    step(1'b0, 32'h0); check_eq("t4_next_fetch", 32'(ph_m), 32'(P_F));

    // Halt: halt_req ignored outside exec2, then halted state is frozen
    halt_req = 1'b1;
    step(1'b0, 32'h08000000); check_eq("t5_fetch_ignores_halt", 32'(ph_m), 32'(P_E1));
    step(1'b0, 32'h0);        check_eq("t5_exec1_ignores_halt", 32'(ph_m), 32'(P_E2));
    step(1'b0, 32'h0);        check_eq("t5_halted", 32'(ph_m), 32'(P_H));
    for (int i = 0; i < 10; i++) begin
      mem_op      = 1'($urandom_range(0, 1));
      mem_is_load = 1'($urandom_range(0, 1));
      halt_req    = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), $urandom);
      check_eq("t5_halt_hold", 32'(ph_m), 32'(P_H));
    end
    check_eq("t5_instr", if_m.instr_reg, 32'h08000000);
    check_eq("t5_data", if_m.data_reg, 32'hDEADBEEF);
    check_eq("t5_stall", 32'(if_m.stall_count), 32'd5);
    check_eq("t5_buserr", 32'(if_m.bus_error), 32'h0);

    // Watchdog (TIMEOUT_CYCLES=4): stuck waitrequest in fetch
    mem_op = 1'b0; mem_is_load = 1'b0; halt_req = 1'b0;
    do_reset();
    step(1'b1, 32'hAAAA0001); check_eq("t6_fetch", 32'(ph_t), 32'(P_F));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hAAAA0001);
      check_eq("t6_stall_phase", 32'(ph_t), 32'(P_F));
      check_eq("t6_no_err_yet", 32'(if_t.bus_error), 32'h0);
    end
    step(1'b1, 32'hAAAA0001);
    check_eq("t6_err_halted", 32'(ph_t), 32'(P_H));
    check_eq("t6_buserr", 32'(if_t.bus_error), 32'h1);
    check_eq("t6_instr_kept", if_t.instr_reg, 32'h0);
    check_eq("t6_stall", 32'(if_t.stall_count), 32'd4);
    for (int i = 0; i < 3; i++) step(1'b0, 32'hBBBB0002);
    check_eq("t6_sticky", 32'(if_t.bus_error), 32'h1);
    check_eq("t6_still_halted", 32'(ph_t), 32'(P_H));
    reset = 1'b0;
    step(1'b0, 32'h0);
    check_eq("t6_err_cleared", 32'(if_t.bus_error), 32'h0);
    reset = 1'b1;

    // Completion on the would-expire cycle wins; wait counter restarts per phase
    step(1'b1, 32'h0); check_eq("t7_fetch", 32'(ph_t), 32'(P_F));
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0);
    step(1'b0, 32'h12340001);
    check_eq("t7_exec1", 32'(ph_t), 32'(P_E1));
    check_eq("t7_no_err", 32'(if_t.bus_error), 32'h0);
    check_eq("t7_instr", if_t.instr_reg, 32'h12340001);
    mem_op = 1'b1; mem_is_load = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0);
    check_eq("t7_e1_stalling", 32'(ph_t), 32'(P_E1));
    step(1'b0, 32'hCAFEF00D);
    check_eq("t7_exec2", 32'(ph_t), 32'(P_E2));
    check_eq("t7_data", if_t.data_reg, 32'hCAFEF00D);
    check_eq("t7_no_err2", 32'(if_t.bus_error), 32'h0);

    // Reset in the middle of an exec1 stall
    do_reset();
    step(1'b0, 32'h0);        check_eq("t8_fetch", 32'(ph_m), 32'(P_F));
    step(1'b0, 32'h8C090004); check_eq("t8_exec1", 32'(ph_m), 32'(P_E1));
    step(1'b1, 32'h0);
    step(1'b1, 32'h0);
    check_eq("t8_stall_pre", 32'(if_m.stall_count), 32'd2);
    reset = 1'b0;
    step(1'b1, 32'h0);
    held_instr = if_m.instr_reg;
    check_eq("t8_rst_phase", 32'(ph_m), 32'(P_IDLE));
    check_eq("t8_rst_instr", held_instr, 32'h0);
    check_eq("t8_rst_stall", 32'(if_m.stall_count), 32'h0);
    reset = 1'b1;
    step(1'b0, 32'h0); check_eq("t8_restart_fetch", 32'(ph_m), 32'(P_F));

    // Stall counter saturation (STALL_W=3): 10 stalls -> 7
    mem_op = 1'b1; mem_is_load = 1'b0;
    do_reset();
    step(1'b1, 32'h0); check_eq("t9_fetch", 32'(ph_s), 32'(P_F));
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0);
    check_eq("t9_stall5", 32'(if_s.stall_count), 32'd5);
    step(1'b0, 32'h0); check_eq("t9_exec1", 32'(ph_s), 32'(P_E1));
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0);
    check_eq("t9_saturated", 32'(if_s.stall_count), 32'd7);
    check_eq("t9_no_err", 32'(if_s.bus_error), 32'h0);
    step(1'b0, 32'h0); check_eq("t9_exec2", 32'(ph_s), 32'(P_E2));
    check_eq("t9_sat_hold", 32'(if_s.stall_count), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
